ioctl_sdram_loader: RTL and testbench
=====================================

Name: ioctl_sdram_loader

Overview:
- Sits between the data_io SPI download block and the SDRAM controller's CPU/loader port.
- Buffers ioctl download bytes in a small FIFO and relocates them to their SDRAM region based on ioctl_index.
- Issues exactly one SDRAM write per mem_sync slot.
- Routes CMOS image bytes (index 0xFF) straight to the CMOS RAM port. Keeps loader_active asserted until every buffered byte has been written, so the core reset does not release early.

Parameters:
- FIFO_DEPTH, 4, entries in the byte FIFO; power of two, minimum 2.
- ROM_BASE, 25'h080000, SDRAM base for ioctl_index 0 (ROM image).
- AUX_BASE, 25'h068000, SDRAM base for any other index except 0xFF.
- CMOS_INDEX, 8'hFF, index routed to the CMOS port instead of SDRAM.

Ports:
- clk_sys  in  1  system clock (48 MHz)
- reset  in  1  asynchronous, active-high reset
- ioctl_download  in  1  download in progress (from data_io)
- ioctl_index  in  8  image type being downloaded
- ioctl_wr  in  1  one-cycle byte strobe
- ioctl_addr  in  25  byte offset within the image
- ioctl_dout  in  8  byte data
- mem_sync  in  1  one-cycle SDRAM slot strobe from the core
- loader_active  out  1  download active or FIFO not yet drained
- loader_we  out  1  SDRAM write request, valid for one mem_sync period
- loader_addr  out  25  SDRAM byte address
- loader_data  out  8  SDRAM write data
- cmos_we  out  1  one-cycle CMOS write strobe
- cmos_addr  out  7  CMOS byte address
- cmos_di  out  8  CMOS write data
- overflow  out  1  sticky flag: a byte was dropped because the FIFO was full
- load_done  out  1  one-cycle pulse when loader_active falls

Behaviour:
- Reset (async, active-high) values:
  - All outputs 0.
  - FIFO empty; read and write pointers 0.
  - Previous-download register 0.
- Push:
  - Occurs when ioctl_wr && ioctl_download && ioctl_index != CMOS_INDEX.
  - Entry = {addr, data}, where addr = ioctl_addr + (ioctl_index==0 ? ROM_BASE : AUX_BASE), truncated mod 2^25.
  - Address is computed at push time using the index present in that cycle.
- CMOS path:
  - Occurs when ioctl_wr && ioctl_download && ioctl_index == CMOS_INDEX.
  - Next cycle: cmos_we=1, cmos_addr=ioctl_addr[6:0], cmos_di=ioctl_dout. Latency 1; the FIFO is bypassed.
- ioctl_wr while ioctl_download=0: ignored entirely.
- Pop/issue, evaluated only in cycles with mem_sync=1:
  - FIFO non-empty: pop the head; next cycle loader_we=1 and loader_addr/loader_data = head entry.
  - FIFO empty: loader_we=0 next cycle. loader_addr/loader_data hold their last values.
  - loader_we, loader_addr and loader_data are stable between consecutive mem_sync strobes. At most one write is issued per slot.
- Simultaneous push and pop in the same cycle: both take effect; occupancy is unchanged. A push into a full FIFO is allowed only if a pop occurs in the same cycle.
- Full:
  - A push with the FIFO full and no concurrent pop is dropped, and overflow is set.
  - overflow clears only on reset or on a rising edge of ioctl_download.
- Empty: no underflow possible; a pop is suppressed when empty.
- Pointers wrap modulo FIFO_DEPTH. An explicit count (log2(FIFO_DEPTH)+1 bits) distinguishes full from empty.
- loader_active = ioctl_download | FIFO non-empty | loader_we (registered).
  - When ioctl_download falls with data buffered, loader_active stays high until the last entry has been issued and the following mem_sync drops loader_we.
- load_done: one-cycle pulse the cycle after loader_active goes 1->0.
- A new download starting (ioctl_download rising) while the FIFO is still draining: no flush. Old entries issue first, in order.
- Reset mid-operation: FIFO contents are discarded and loader_we is deasserted immediately (asynchronous). load_done is not pulsed.

Test Plan:
- Index 0, bytes 0xA5 at ioctl_addr 0 and 0x5A at ioctl_addr 1, with mem_sync every 8 cycles -> two writes in successive slots: (0x080000, 0xA5) then (0x080001, 0x5A). Each loader_we lasts exactly 8 cycles. load_done pulses once after the download ends and the FIFO is drained.
- Index 0x41, byte 0x33 at ioctl_addr 0x10 -> loader_addr = 0x068010, loader_data = 0x33.
- Index 0xFF, byte 0x7E at ioctl_addr 0x85 -> cmos_we pulses for 1 cycle with cmos_addr = 0x05, cmos_di = 0x7E; no loader_we.
- FIFO_DEPTH=4: 6 ioctl_wr strobes back-to-back with mem_sync held low -> first 4 bytes retained, overflow=1. Afterwards, 4 writes are issued in order. overflow clears on the next ioctl_download rise.
- ioctl_download falls with 3 entries queued -> loader_active stays 1 through 3 further slots plus one, then falls; load_done pulses once.
- Assert reset while 2 entries are queued and loader_we=1 -> all outputs 0 immediately. After release, no stale writes are issued and load_done never pulses.

Source files
------------

// File: rtl/ioctl_sdram_loader.sv
// Buffers ioctl download bytes in a small FIFO and writes them to their SDRAM region,
// one write per mem_sync slot; CMOS image bytes bypass the FIFO to the CMOS RAM port.
module ioctl_sdram_loader #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [24:0] ROM_BASE   = 25'h080000,
  parameter logic [24:0] AUX_BASE   = 25'h068000,
  parameter logic [7:0]  CMOS_INDEX = 8'hFF
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        mem_sync,
  output logic        loader_active,
  output logic        loader_we,
  output logic [24:0] loader_addr,
  output logic [7:0]  loader_data,
  output logic        cmos_we,
  output logic [6:0]  cmos_addr,
  output logic [7:0]  cmos_di,
  output logic        overflow,
  output logic        load_done
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [24:0] addr;
    logic [7:0]  data;
  } entry_t;

  entry_t             mem_q [FIFO_DEPTH];
  entry_t             mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               loader_we_q, loader_we_d;
  logic [24:0]        loader_addr_q, loader_addr_d;
  logic [7:0]         loader_data_q, loader_data_d;
  logic               cmos_we_q, cmos_we_d;
  logic [6:0]         cmos_addr_q, cmos_addr_d;
  logic [7:0]         cmos_di_q, cmos_di_d;
  logic               overflow_q, overflow_d;
  logic               active_q, active_d;
  logic               active_prev_q, active_prev_d;
  logic               load_done_q, load_done_d;
  logic               dl_prev_q, dl_prev_d;

  logic               push_req, cmos_req, push, pop, fifo_empty, fifo_full;
  entry_t             push_entry;

  // Next-state: FIFO bookkeeping, slot-aligned write issue, CMOS bypass, status flags
  always_comb begin
    mem_d          = mem_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    loader_we_d    = loader_we_q;
    loader_addr_d  = loader_addr_q;
    loader_data_d  = loader_data_q;
    cmos_we_d      = 1'b0;
    cmos_addr_d    = cmos_addr_q;
    cmos_di_d      = cmos_di_q;
    overflow_d     = overflow_q;
    dl_prev_d      = ioctl_download;
    active_prev_d  = active_q;

    push_req   = ioctl_wr & ioctl_download & (ioctl_index != CMOS_INDEX);
    cmos_req   = ioctl_wr & ioctl_download & (ioctl_index == CMOS_INDEX);
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    pop        = mem_sync & ~fifo_empty;
    push       = push_req & (~fifo_full | pop);

    push_entry.addr = ioctl_addr + ((ioctl_index == 8'h00) ? ROM_BASE : AUX_BASE);
    push_entry.data = ioctl_dout;

    if (push) begin
      mem_d[wr_ptr_q] = push_entry;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end

    // Outputs only move on a slot strobe, so they stay stable for a whole slot
    if (mem_sync) begin
      loader_we_d = pop;
      if (pop) begin
        loader_addr_d = mem_q[rd_ptr_q].addr;
        loader_data_d = mem_q[rd_ptr_q].data;
        rd_ptr_d      = rd_ptr_q + PTR_W'(1);
      end
    end

    count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    if (cmos_req) begin
      cmos_we_d   = 1'b1;
      cmos_addr_d = ioctl_addr[6:0];
      cmos_di_d   = ioctl_dout;
    end

    if (ioctl_download & ~dl_prev_q) overflow_d = 1'b0;
    if (push_req & ~push)            overflow_d = 1'b1;

    active_d    = ioctl_download | (count_d != '0) | loader_we_d;
    load_done_d = active_prev_q & ~active_q;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      mem_q         <= '{default: '0};
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      loader_we_q   <= 1'b0;
      loader_addr_q <= '0;
      loader_data_q <= '0;
      cmos_we_q     <= 1'b0;
      cmos_addr_q   <= '0;
      cmos_di_q     <= '0;
      overflow_q    <= 1'b0;
      active_q      <= 1'b0;
      active_prev_q <= 1'b0;
      load_done_q   <= 1'b0;
      dl_prev_q     <= 1'b0;
    end else begin
      mem_q         <= mem_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      loader_we_q   <= loader_we_d;
      loader_addr_q <= loader_addr_d;
      loader_data_q <= loader_data_d;
      cmos_we_q     <= cmos_we_d;
      cmos_addr_q   <= cmos_addr_d;
      cmos_di_q     <= cmos_di_d;
      overflow_q    <= overflow_d;
      active_q      <= active_d;
      active_prev_q <= active_prev_d;
      load_done_q   <= load_done_d;
      dl_prev_q     <= dl_prev_d;
    end
  end

  assign loader_active = active_q;
  assign loader_we     = loader_we_q;
  assign loader_addr   = loader_addr_q;
  assign loader_data   = loader_data_q;
  assign cmos_we       = cmos_we_q;
  assign cmos_addr     = cmos_addr_q;
  assign cmos_di       = cmos_di_q;
  assign overflow      = overflow_q;
  assign load_done     = load_done_q;

endmodule

// File: tb/tb_ioctl_sdram_loader.sv
// Directed bench for ioctl_sdram_loader: scoreboard queues for SDRAM and CMOS writes,
// plus a per-cycle monitor for slot stability and the load_done pulse.
module tb_ioctl_sdram_loader;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = '0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        mem_sync = 1'b0;
  logic        loader_active, loader_we, cmos_we, overflow, load_done;
  logic [24:0] loader_addr;
  logic [7:0]  loader_data, cmos_di;
  logic [6:0]  cmos_addr;

  int checks = 0;
  int errors = 0;
  int done_count = 0;
  int sync_count = 0;
  bit sync_en = 1'b0;
  logic [2:0] sync_cnt = '0;

  logic [32:0] exp_q[$];
  logic [14:0] cmos_q[$];

  ioctl_sdram_loader dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .mem_sync(mem_sync), .loader_active(loader_active),
    .loader_we(loader_we), .loader_addr(loader_addr), .loader_data(loader_data),
    .cmos_we(cmos_we), .cmos_addr(cmos_addr), .cmos_di(cmos_di),
    .overflow(overflow), .load_done(load_done)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Slot strobe: one cycle in every eight while enabled
  always @(negedge clk_sys) begin
    if (!sync_en) begin
      sync_cnt = '0;
      mem_sync = 1'b0;
    end else begin
      sync_cnt = sync_cnt + 3'd1;
      mem_sync = (sync_cnt == 3'd7);
    end
  end

  logic        prev_we, prev_cmos, a1, a2;
  logic [24:0] prev_addr;
  logic [7:0]  prev_data;
  bit          hist_valid = 1'b0;
  logic [32:0] exp_w;
  logic [14:0] exp_c;

  always @(posedge clk_sys) begin
    logic se;
    se = mem_sync;
    #1;
    if (reset) begin
      hist_valid = 1'b0;
      a1 = 1'b0; a2 = 1'b0; prev_cmos = 1'b0;
    end else begin
      if (se) sync_count++;
      if (hist_valid && !se) begin
        check("we_stable", 64'(loader_we), 64'(prev_we));
        check("addr_stable", 64'(loader_addr), 64'(prev_addr));
        check("data_stable", 64'(loader_data), 64'(prev_data));
      end
      if (se && loader_we) begin
        check("write_expected", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0) begin
          exp_w = exp_q.pop_front();
          check("write_addr", 64'(loader_addr), 64'(exp_w[32:8]));
          check("write_data", 64'(loader_data), 64'(exp_w[7:0]));
        end
      end
      if (cmos_we) begin
        check("cmos_one_cycle", 64'(prev_cmos), 64'(0));
        check("cmos_expected", 64'(cmos_q.size() != 0), 64'(1));
        if (cmos_q.size() != 0) begin
          exp_c = cmos_q.pop_front();
          check("cmos_addr", 64'(cmos_addr), 64'(exp_c[14:8]));
          check("cmos_di", 64'(cmos_di), 64'(exp_c[7:0]));
        end
      end
      check("load_done_timing", 64'(load_done), 64'(!a1 && a2));
      if (load_done) done_count++;
      a2 = a1; a1 = loader_active;
      prev_we = loader_we; prev_addr = loader_addr; prev_data = loader_data;
      prev_cmos = cmos_we;
      hist_valid = 1'b1;
    end
  end

  task automatic write_byte(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d);
    @(negedge clk_sys);
    ioctl_index = idx; ioctl_addr = a; ioctl_dout = d; ioctl_wr = 1'b1;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 400 && (exp_q.size() != 0 || loader_active); i++) @(negedge clk_sys);
    check(tag, 64'(exp_q.size() == 0 && !loader_active), 64'(1));
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk_sys);
  endtask

  initial begin
    int d0, s0;
    // Reset state
    cycles(2);
    check("rst_active", 64'(loader_active), 64'(0));
    check("rst_we", 64'(loader_we), 64'(0));
    check("rst_addr", 64'(loader_addr), 64'(0));
    check("rst_data", 64'(loader_data), 64'(0));
    check("rst_cmos_we", 64'(cmos_we), 64'(0));
    check("rst_overflow", 64'(overflow), 64'(0));
    check("rst_load_done", 64'(load_done), 64'(0));
    reset = 1'b0;
    sync_en = 1'b1;
    cycles(3);

    // ROM image, two bytes
    d0 = done_count;
    ioctl_download = 1'b1;
    exp_q.push_back({25'h080000, 8'hA5});
    exp_q.push_back({25'h080001, 8'h5A});
    write_byte(8'h00, 25'h0, 8'hA5);
    write_byte(8'h00, 25'h1, 8'h5A);
    ioctl_download = 1'b0;
    wait_drain("rom_drain");
    cycles(3);
    check("rom_load_done_once", 64'(done_count - d0), 64'(1));

    // Auxiliary index relocation
    ioctl_download = 1'b1;
    exp_q.push_back({25'h068010, 8'h33});
    write_byte(8'h41, 25'h10, 8'h33);
    ioctl_download = 1'b0;
    wait_drain("aux_drain");

    // CMOS bypass
    ioctl_download = 1'b1;
    cmos_q.push_back({7'h05, 8'h7E});
    write_byte(8'hFF, 25'h85, 8'h7E);
    check("cmos_we_next", 64'(cmos_we), 64'(1));
    check("cmos_addr_next", 64'(cmos_addr), 64'(7'h05));
    check("cmos_di_next", 64'(cmos_di), 64'(8'h7E));
    @(negedge clk_sys);
    check("cmos_we_drop", 64'(cmos_we), 64'(0));
    ioctl_download = 1'b0;
    wait_drain("cmos_drain");
    check("cmos_consumed", 64'(cmos_q.size()), 64'(0));

    // Ignored strobe without download
    write_byte(8'h00, 25'h20, 8'h99);
    cycles(20);
    check("idle_no_active", 64'(loader_active), 64'(0));

    // Overflow: six back-to-back bytes with no slots
    sync_en = 1'b0;
    cycles(2);
    ioctl_download = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_sys);
      ioctl_index = 8'h00; ioctl_addr = 25'(32'h40 + i); ioctl_dout = 8'(8'hC0 + i);
      ioctl_wr = 1'b1;
      if (i < 4) exp_q.push_back({25'(32'h080040 + i), 8'(8'hC0 + i)});
    end
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    check("ovf_set", 64'(overflow), 64'(1));
    check("ovf_active", 64'(loader_active), 64'(1));
    sync_en = 1'b1;
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk_sys);
    check("ovf_four_issued", 64'(exp_q.size()), 64'(0));
    check("ovf_sticky", 64'(overflow), 64'(1));
    ioctl_download = 1'b0;
    wait_drain("ovf_drain");
    check("ovf_sticky_after_end", 64'(overflow), 64'(1));

    // New download clears overflow; download falls with three entries queued
    sync_en = 1'b0;
    cycles(2);
    ioctl_download = 1'b1;
    @(negedge clk_sys);
    check("ovf_clear_on_rise", 64'(overflow), 64'(0));
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({25'(32'h080100 + i), 8'(8'h10 + i)});
      write_byte(8'h00, 25'(32'h100 + i), 8'(8'h10 + i));
    end
    ioctl_download = 1'b0;
    d0 = done_count;
    cycles(2);
    check("tail_active_held", 64'(loader_active), 64'(1));
    s0 = sync_count;
    sync_en = 1'b1;
    for (int i = 0; i < 200 && loader_active; i++) @(negedge clk_sys);
    check("tail_active_fell", 64'(loader_active), 64'(0));
    check("tail_slots", 64'(sync_count - s0), 64'(4));
    check("tail_all_issued", 64'(exp_q.size()), 64'(0));
    cycles(3);
    check("tail_load_done_once", 64'(done_count - d0), 64'(1));

    // Reset with entries queued and a write in flight
    sync_en = 1'b0;
    cycles(2);
    ioctl_download = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({25'(32'h080200 + i), 8'(8'h60 + i)});
      write_byte(8'h00, 25'(32'h200 + i), 8'(8'h60 + i));
    end
    sync_en = 1'b1;
    for (int i = 0; i < 100 && !loader_we; i++) @(negedge clk_sys);
    sync_en = 1'b0;
    check("rst_mid_we_before", 64'(loader_we), 64'(1));
    check("rst_mid_queued", 64'(exp_q.size()), 64'(2));
    d0 = done_count;
    @(negedge clk_sys);
    reset = 1'b1;
    #1;
    check("rst_mid_we", 64'(loader_we), 64'(0));
    check("rst_mid_active", 64'(loader_active), 64'(0));
    check("rst_mid_addr", 64'(loader_addr), 64'(0));
    check("rst_mid_data", 64'(loader_data), 64'(0));
    check("rst_mid_overflow", 64'(overflow), 64'(0));
    exp_q.delete();
    ioctl_download = 1'b0;
    cycles(2);
    reset = 1'b0;
    sync_en = 1'b1;
    cycles(40);
    check("rst_mid_no_done", 64'(done_count - d0), 64'(0));
    check("rst_mid_idle", 64'(loader_active), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL timeout: observed no finish expected finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
